// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the stage controller: widths, icodes, status and
// condition encodings, stage state encoding and one-hot strobe patterns.
package y86_pkg;

  localparam int unsigned ICODE_W = 4;
  localparam int unsigned IFUN_W  = 4;
  localparam int unsigned STAT_W  = 3;
  localparam int unsigned CC_W    = 3;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned STRB_W  = 6;

  localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
  localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
  localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;

  localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
  localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
  localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
  localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

  localparam logic [IFUN_W-1:0] C_YES = 4'd0;
  localparam logic [IFUN_W-1:0] C_LE  = 4'd1;
  localparam logic [IFUN_W-1:0] C_L   = 4'd2;
  localparam logic [IFUN_W-1:0] C_E   = 4'd3;
  localparam logic [IFUN_W-1:0] C_NE  = 4'd4;
  localparam logic [IFUN_W-1:0] C_GE  = 4'd5;
  localparam logic [IFUN_W-1:0] C_G   = 4'd6;

  // Strobe order: {fetch, decode, execute, memory, writeback, pc}
  localparam logic [STRB_W-1:0] STRB_FETCH = 6'b100000;
  localparam logic [STRB_W-1:0] STRB_DEC   = 6'b010000;
  localparam logic [STRB_W-1:0] STRB_EXE   = 6'b001000;
  localparam logic [STRB_W-1:0] STRB_MEM   = 6'b000100;
  localparam logic [STRB_W-1:0] STRB_WB    = 6'b000010;
  localparam logic [STRB_W-1:0] STRB_PC    = 6'b000001;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = 3'b100;

  // Instructions whose ifun selects a branch/cmov condition.
  function automatic logic is_cond_icode(input logic [ICODE_W-1:0] ic);
    return (ic == I_RRMOVQ) || (ic == I_JXX);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch/cmov condition from condition codes and ifun.
module cond_eval
  import y86_pkg::*;
(
  input  cc_t               cc,
  input  logic [IFUN_W-1:0] ifun,
  output logic              cond
);

  logic w_lt;

  assign w_lt = cc.sf ^ cc.of;

  always_comb begin
    cond = 1'b0;
    case (ifun)
      C_YES:   cond = 1'b1;
      C_LE:    cond = w_lt | cc.zf;
      C_L:     cond = w_lt;
      C_E:     cond = cc.zf;
      C_NE:    cond = ~cc.zf;
      C_GE:    cond = ~w_lt;
      C_G:     cond = ~w_lt & ~cc.zf;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/stage_ctrl.sv
// Sequential Y86 stage controller: one-hot stage strobes, condition codes,
// branch condition and status. STAGE_CTRL_INSTR_CNT_EN adds an instruction counter.
module stage_ctrl
  import y86_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ICODE_W-1:0] icode,
  input  logic [IFUN_W-1:0]  ifun,
  input  logic               instr_valid,
  input  logic               imem_error,
  input  logic               dmem_error,
  input  logic               alu_zf,
  input  logic               alu_sf,
  input  logic               alu_of,
  output logic               fetch_en,
  output logic               decode_en,
  output logic               execute_en,
  output logic               memory_en,
  output logic               writeback_en,
  output logic               pc_en,
  output logic [CC_W-1:0]    cc,
  output logic               cnd,
  output logic [STAT_W-1:0]  stat,
  output logic               halted
`ifdef STAGE_CTRL_INSTR_CNT_EN
  ,
  output logic [31:0]        instr_cnt
`endif
);

  state_t              r_state;
  state_t              w_next_state;
  logic [STRB_W-1:0]   r_strobe;
  logic [STRB_W-1:0]   w_strobe_next;
  logic [STAT_W-1:0]   r_stat;
  logic [STAT_W-1:0]   w_stat_next;
  cc_t                 r_cc;
  logic                r_cnd;
  logic                r_halted;
  logic                w_cond;
  logic                w_cc_load;
  logic                w_cnd_load;
  logic                w_cnd_next;

  cond_eval u_cond_eval (
    .cc   (r_cc),
    .ifun (ifun),
    .cond (w_cond)
  );

  // cnd is evaluated against cc before this cycle's OPq update.
  assign w_cc_load  = (r_state == S_EXECUTE) && (icode == I_OPQ);
  assign w_cnd_load = (r_state == S_EXECUTE);
  assign w_cnd_next = is_cond_icode(icode) ? w_cond : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_strobe <= '0;
      r_stat   <= STAT_AOK;
      r_cc     <= CC_RESET;
      r_cnd    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_strobe <= w_strobe_next;
      r_stat   <= w_stat_next;
      r_halted <= (w_next_state == S_HALT);
      if (w_cc_load) begin
        r_cc <= cc_t'({alu_zf, alu_sf, alu_of});
      end
      if (w_cnd_load) begin
        r_cnd <= w_cnd_next;
      end
    end
  end

  // Next state, fault status and strobe pattern of the next state.
  always_comb begin
    w_next_state  = r_state;
    w_stat_next   = r_stat;
    w_strobe_next = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_error) begin
          w_stat_next  = STAT_ADR;
          w_next_state = S_HALT;
        end else if (!instr_valid) begin
          w_stat_next  = STAT_INS;
          w_next_state = S_HALT;
        end else if (icode == I_HALT) begin
          w_stat_next  = STAT_HLT;
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_DECODE;
        end
      end
      S_DECODE:    w_next_state = S_EXECUTE;
      S_EXECUTE:   w_next_state = S_MEMORY;
      S_MEMORY: begin
        if (dmem_error) begin
          w_stat_next  = STAT_ADR;
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_WRITEBACK;
        end
      end
      S_WRITEBACK: w_next_state = S_PCUPD;
      S_PCUPD:     w_next_state = S_FETCH;
      S_HALT:      w_next_state = S_HALT;
      default:     w_next_state = S_IDLE;
    endcase

    case (w_next_state)
      S_FETCH:     w_strobe_next = STRB_FETCH;
      S_DECODE:    w_strobe_next = STRB_DEC;
      S_EXECUTE:   w_strobe_next = STRB_EXE;
      S_MEMORY:    w_strobe_next = STRB_MEM;
      S_WRITEBACK: w_strobe_next = STRB_WB;
      S_PCUPD:     w_strobe_next = STRB_PC;
      default:     w_strobe_next = '0;
    endcase
  end

  assign {fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en} = r_strobe;
  assign cc     = r_cc;
  assign cnd    = r_cnd;
  assign stat   = r_stat;
  assign halted = r_halted;

`ifdef STAGE_CTRL_INSTR_CNT_EN
  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] r_instr_cnt;

  // Counts completed instructions; wraps naturally and cannot move in HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
    end else if (r_state == S_PCUPD) begin
      r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: doc/stage_ctrl.md
STAGE_CTRL -- requirements
Module: stage_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, rising-edge active.
REQ-002 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  input  1  one-cycle pulse, begins execution from IDLE.
REQ-004 SHALL have ports: icode/ifun  input  4/4  current instruction fields, valid from end of FETCH.
REQ-005 SHALL have ports: instr_valid, imem_error  input  1/1  fetch status, sampled in FETCH.
REQ-006 SHALL have ports: dmem_error  input  1  data-memory fault, sampled in MEMORY.
REQ-007 SHALL have ports: alu_zf, alu_sf, alu_of  input  1 each  ALU flags for the current OPq result.
REQ-008 SHALL have ports: fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en  output  1 each  one-hot stage strobes.
REQ-009 SHALL have ports: cc  output  3  {ZF,SF,OF}; cnd  output  1  registered branch/cmov condition.
REQ-010 SHALL have ports: stat  output  3  AOK=1, HLT=2, ADR=3, INS=4; halted  output  1.

Function
REQ-011 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT; one cycle per stage state.
REQ-012 SHALL assert exactly the strobe matching the current stage state, none in IDLE/HALT.
REQ-013 SHALL move IDLE->FETCH on start; start in any other state is ignored.
REQ-014 SHALL sequence FETCH->DECODE->EXECUTE->MEMORY->WRITEBACK->PCUPD->FETCH when no fault.
REQ-015 SHALL, in FETCH, check in priority imem_error (stat=ADR), !instr_valid (stat=INS), icode==0 (stat=HLT); any hit -> HALT next cycle, no further strobes, PC not updated.
REQ-016 SHALL, in MEMORY, on dmem_error set stat=ADR and go to HALT; WRITEBACK and PCUPD skipped.
REQ-017 SHALL, in EXECUTE with icode==6, load cc <= {alu_zf,alu_sf,alu_of} at the end of the cycle; other icodes leave cc unchanged.
REQ-018 SHALL, in EXECUTE with icode 2 or 7, register cnd from pre-update cc per ifun: 0 always; 1 (SF^OF)|ZF; 2 SF^OF; 3 ZF; 4 !ZF; 5 !(SF^OF); 6 !(SF^OF)&!ZF; ifun>6 -> 0.
REQ-019 SHALL hold cnd from EXECUTE until the next EXECUTE; cnd is 0 for other icodes.
REQ-020 SHALL remain in HALT with halted=1 and stat frozen until reset.
REQ-021 SHALL keep stat=AOK in all non-HALT states after reset.

Reset
REQ-022 SHALL on rst_n low asynchronously force: state=IDLE, all strobes 0, cc=3'b100, cnd=0, stat=AOK, halted=0.
REQ-023 SHALL abort any in-flight instruction on reset mid-sequence; no strobe fires in the cycle after rst_n deasserts.

Configuration
REQ-024 SHALL, with STAGE_CTRL_INSTR_CNT_EN defined, provide output instr_cnt[31:0], reset 0, +1 on each PCUPD, wrapping 0xFFFFFFFF->0, frozen in HALT.
REQ-025 SHALL, without STAGE_CTRL_INSTR_CNT_EN, omit instr_cnt port and counter logic; all other behaviour identical.

Structure
REQ-026 SHALL take icode constants, stat encodings, cond ifun codes and the state encoding from shared package y86_pkg.
REQ-027 SHALL place REQ-018 condition logic in combinational sub-module cond_eval (cc, ifun -> cond).

Verification
REQ-028 SHALL test: reset, start, icode=3 valid -> strobes FETCH..PCUPD on cycles 1..6, back to FETCH on cycle 7, stat=1.
REQ-029 SHALL test: OPq icode=6 with zf=0,sf=1,of=0 -> cc=3'b010 after EXECUTE; next jxx ifun=2 -> cnd=1, ifun=3 -> cnd=0.
REQ-030 SHALL test: fetch icode=0 -> HALT after FETCH, stat=2, halted=1, no pc_en; start pulse ignored.
REQ-031 SHALL test: dmem_error=1 in MEMORY -> stat=3, no writeback_en/pc_en, HALT held for 10 cycles.
REQ-032 SHALL test: imem_error=1 and instr_valid=0 together -> stat=3 (ADR priority).
REQ-033 SHALL test: rst_n low during EXECUTE -> all outputs at reset values immediately; with STAGE_CTRL_INSTR_CNT_EN, instr_cnt returns to 0.
